// File: rtl/na_conf_fetch_pkg.sv
// Shared definitions for the NoC adapter configuration fetcher:
// register map, AHB-Lite encodings and the fetch FSM states.
package na_conf_fetch_pkg;

    localparam logic [3:0] REG_TILEID   = 4'd0;
    localparam logic [3:0] REG_NUMTILES = 4'd1;
    localparam logic [3:0] REG_CONF     = 4'd3;
    localparam logic [3:0] REG_COREBASE = 4'd4;
    localparam logic [3:0] REG_NUMCTS   = 4'd10;

    localparam logic [2:0] LAST_IDX = 3'd4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // Byte offset of the idx-th register in fetch order.
    function automatic logic [15:0] reg_offset(input logic [2:0] idx);
        logic [3:0] word;
        case (idx)
            3'd0:    word = REG_TILEID;
            3'd1:    word = REG_NUMTILES;
            3'd2:    word = REG_CONF;
            3'd3:    word = REG_COREBASE;
            default: word = REG_NUMCTS;
        endcase
        return {10'd0, word, 2'b00};
    endfunction

endpackage

// File: rtl/na_conf_fetch.sv
// Reads the tile configuration block over AHB-Lite, one single
// non-sequential word read per register, with per-beat timeout.
module na_conf_fetch
    import na_conf_fetch_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [15:0] BASE      = 16'h0000,
    parameter bit          AUTOSTART = 1'b1,
    parameter int          TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic            conf_valid,
    output logic [XLEN-1:0] tile_id,
    output logic [XLEN-1:0] num_tiles,
    output logic [XLEN-1:0] corebase,
    output logic [XLEN-1:0] num_cts,
    output logic [1:0]      conf_flags,
    output logic            hsel,
    output logic [15:0]     haddr,
    output logic [XLEN-1:0] hwdata,
    output logic            hwrite,
    output logic [2:0]      hsize,
    output logic [2:0]      hburst,
    output logic [3:0]      hprot,
    output logic [1:0]      htrans,
    output logic            hmastlock,
    input  logic [XLEN-1:0] hrdata,
    input  logic            hready,
    input  logic            hresp
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            arm_q, arm_d;
    logic            error_q, error_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] tile_id_q, tile_id_d;
    logic [XLEN-1:0] num_tiles_q, num_tiles_d;
    logic [XLEN-1:0] corebase_q, corebase_d;
    logic [XLEN-1:0] num_cts_q, num_cts_d;
    logic [1:0]      conf_flags_q, conf_flags_d;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        arm_d        = 1'b0;
        error_d      = error_q;
        valid_d      = valid_q;
        tile_id_d    = tile_id_q;
        num_tiles_d  = num_tiles_q;
        corebase_d   = corebase_q;
        num_cts_d    = num_cts_q;
        conf_flags_d = conf_flags_q;
        case (state_q)
            ST_IDLE: begin
                // arm_q is only set in the first cycle after reset
                if (start || (AUTOSTART && arm_q)) begin
                    state_d = ST_ADDR;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    error_d = 1'b0;
                    valid_d = 1'b0;
                end
            end
            ST_ADDR: begin
                if (hready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (hresp) begin
                    state_d = ST_ERR;
                end else if (hready) begin
                    case (idx_q)
                        3'd0:    tile_id_d    = hrdata;
                        3'd1:    num_tiles_d  = hrdata;
                        3'd2:    conf_flags_d = hrdata[1:0];
                        3'd3:    corebase_d   = hrdata;
                        default: num_cts_d    = hrdata;
                    endcase
                    cnt_d = '0;
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= CNT_MAX) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                error_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            arm_q        <= AUTOSTART;
            error_q      <= 1'b0;
            valid_q      <= 1'b0;
            tile_id_q    <= '0;
            num_tiles_q  <= '0;
            corebase_q   <= '0;
            num_cts_q    <= '0;
            conf_flags_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            arm_q        <= arm_d;
            error_q      <= error_d;
            valid_q      <= valid_d;
            tile_id_q    <= tile_id_d;
            num_tiles_q  <= num_tiles_d;
            corebase_q   <= corebase_d;
            num_cts_q    <= num_cts_d;
            conf_flags_q <= conf_flags_d;
        end
    end

    assign busy       = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign done       = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign error      = error_q;
    assign conf_valid = valid_q;
    assign tile_id    = tile_id_q;
    assign num_tiles  = num_tiles_q;
    assign corebase   = corebase_q;
    assign num_cts    = num_cts_q;
    assign conf_flags = conf_flags_q;

    assign hsel      = (state_q == ST_ADDR);
    assign htrans    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr     = BASE + reg_offset(idx_q);
    assign hwdata    = '0;
    assign hwrite    = 1'b0;
    assign hsize     = HSIZE_WORD;
    assign hburst    = HBURST_SINGLE;
    assign hprot     = HPROT_DATA;
    assign hmastlock = 1'b0;

endmodule

// File: doc/na_conf_fetch.md
NA_CONF_FETCH -- requirements
Module: na_conf_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning AHB data width.
REQ-002 SHALL have parameter BASE, default 16'h0000, meaning config-block base address.
REQ-003 SHALL have parameter AUTOSTART, default 1, meaning a fetch starts automatically after reset.
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning maximum wait-state cycles per data phase.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1, fetch request pulse.
REQ-008 SHALL have ports busy, done, error, output, 1 each: fetch active; one-cycle completion pulse; sticky failure flag.
REQ-009 SHALL have port conf_valid, output, 1, all fields hold a complete successful fetch.
REQ-010 SHALL have ports tile_id, num_tiles, corebase, num_cts, output, XLEN each, fetched values.
REQ-011 SHALL have port conf_flags, output, 2: bit0 mp_simple, bit1 dma.
REQ-012 SHALL have AHB-Lite master outputs hsel (1), haddr (16), hwdata (XLEN), hwrite (1), hsize (3), hburst (3), hprot (4), htrans (2), hmastlock (1).
REQ-013 SHALL have AHB-Lite master inputs hrdata (XLEN), hready (1), hresp (1).

Function
REQ-014 SHALL read, in order, offsets 0x00 tile_id, 0x04 num_tiles, 0x0C conf_flags (hrdata[1:0]), 0x10 corebase, 0x28 num_cts; haddr = BASE + offset, 16-bit wrap.
REQ-015 SHALL use FSM states IDLE, ADDR, DATA, DONE, ERR.
REQ-016 IDLE: htrans=IDLE(00), hsel=0; start=1 (or first post-reset cycle if AUTOSTART) -> ADDR, index=0, error=0, conf_valid=0.
REQ-017 ADDR: hsel=1, htrans=NONSEQ(10), hwrite=0, hsize=010, hburst=000, hprot=0011, hmastlock=0, hwdata=0; hready=1 -> DATA; else hold address.
REQ-018 DATA: htrans=IDLE, hsel=0; each cycle with hready=0 increments wait counter; hready=1 and hresp=0 -> capture hrdata into field[index], reset counter; then index<4 -> ADDR, index++, else -> DONE.
REQ-019 hresp=1 in any DATA cycle SHALL -> ERR without capturing; wait counter reaching TIMEOUT SHALL -> ERR.
REQ-020 DONE: exactly one cycle; done=1, conf_valid<=1; -> IDLE.
REQ-021 ERR: exactly one cycle; error<=1 (sticky until next accepted start), done=1, conf_valid stays 0; -> IDLE.
REQ-022 busy SHALL be 1 in ADDR and DATA only.
REQ-023 start while busy SHALL be ignored; start in DONE/ERR cycle SHALL be ignored.
REQ-024 Fields SHALL update individually on capture; previous values retained until overwritten.
REQ-025 Read latency per register SHALL be 2 cycles with zero wait states; full fetch = 10 cycles ADDR/DATA + 1 DONE.
REQ-026 Wait counter SHALL be clog2(TIMEOUT+1) bits, saturating, cleared on entering ADDR.

Reset
REQ-027 On rst: state IDLE, all fields 0, conf_flags 0, conf_valid 0, busy 0, done 0, error 0, htrans IDLE, hsel 0, haddr BASE, index 0, counter 0.
REQ-028 rst mid-fetch SHALL abort immediately with reset values; AUTOSTART re-arms the fetch.

Structure
REQ-029 Register offsets (REG_TILEID=0, REG_NUMTILES=1, REG_CONF=3, REG_COREBASE=4, REG_NUMCTS=10, word index), htrans/hsize encodings and the FSM state enum SHALL live in a shared package.
REQ-030 SHALL be a single module; no sub-module.

Verification
REQ-031 Zero-wait slave, regs 3,16,0x3,8,12, AUTOSTART -> done at cycle 11, conf_valid=1, tile_id=3, num_tiles=16, conf_flags=11, corebase=8, num_cts=12.
REQ-032 Slave inserts 3 wait states on num_tiles data phase -> haddr=0x0004 held, total 14 cycles, values correct.
REQ-033 hresp=1 on corebase read -> ERR, error=1, conf_valid=0, num_cts unchanged, tile_id retained.
REQ-034 hready stuck 0 with TIMEOUT=4 -> ERR after 4 wait cycles; next start clears error and completes.
REQ-035 rst asserted during third read -> all outputs 0 next cycle; refetch starts at offset 0x00.
REQ-036 start pulsed while busy -> ignored; exactly one done pulse observed.
